// File: rtl/breakpoint_pkg.sv
// Shared encodings for the multi-channel breakpoint / watchpoint unit.
package breakpoint_pkg;

  // Channel comparator modes
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_EXEC = 2'b01;
  localparam logic [1:0] MODE_RD   = 2'b10;
  localparam logic [1:0] MODE_WR   = 2'b11;

  // Debug FSM states
  typedef enum logic [1:0] {
    ARMED = 2'd0,
    HIT   = 2'd1,
    SKIP  = 2'd2
  } dbg_state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int chan_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/breakpoint_channel.sv
// One comparator channel: config registers, address/data compare, pass counter.
module breakpoint_channel
  import breakpoint_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_mode,
  input  logic [ADDR_WIDTH-1:0]  cfg_addr,
  input  logic [DATA_WIDTH-1:0]  cfg_data,
  input  logic                   cfg_data_match,
  input  logic [COUNT_WIDTH-1:0] cfg_pass_count,
  input  logic                   match_en,
  input  logic                   exec_en,
  input  logic                   reload,
  input  logic                   instr_start,
  input  logic [ADDR_WIDTH-1:0]  pc,
  input  logic [ADDR_WIDTH-1:0]  ram_addr,
  input  logic                   ram_noe,
  input  logic                   ram_nwe,
  input  logic [DATA_WIDTH-1:0]  bus,
  output logic                   trigger
);

  logic [1:0]             mode;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  data;
  logic                   data_match;
  logic [COUNT_WIDTH-1:0] pass_count;
  logic [COUNT_WIDTH-1:0] cnt;
  logic                   hit;
  logic                   active;

  // Raw comparator; data compare only applies to the watch modes
  always_comb begin
    hit = 1'b0;
    case (mode)
      MODE_EXEC: hit = exec_en && instr_start && (pc == addr);
      MODE_RD:   hit = !ram_noe && (ram_addr == addr) && (!data_match || bus == data);
      MODE_WR:   hit = !ram_nwe && (ram_addr == addr) && (!data_match || bus == data);
      default:   hit = 1'b0;
    endcase
  end

  // A config write to this channel discards its match in the same cycle
  assign active  = match_en && hit && !cfg_we;
  assign trigger = active && (cnt == '0);

  // Config registers and pass counter; config write beats reload beats decrement
  always_ff @(posedge clk) begin
    if (reset) begin
      mode       <= MODE_OFF;
      addr       <= '0;
      data       <= '0;
      data_match <= 1'b0;
      pass_count <= '0;
      cnt        <= '0;
    end else if (cfg_we) begin
      mode       <= cfg_mode;
      addr       <= cfg_addr;
      data       <= cfg_data;
      data_match <= cfg_data_match;
      pass_count <= cfg_pass_count;
      cnt        <= cfg_pass_count;
    end else if (reload) begin
      cnt <= pass_count;
    end else if (active && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/breakpoint_unit.sv
// Multi-channel debug trigger: channel array, halt FSM, hit priority encoder.
module breakpoint_unit
  import breakpoint_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNELS    = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_breakpointEnableN,
  input  logic                          i_instrStart,
  input  logic [ADDR_WIDTH-1:0]         i_pc,
  input  logic [ADDR_WIDTH-1:0]         i_ramAddr,
  input  logic                          i_ramNOE,
  input  logic                          i_ramNWE,
  input  logic [DATA_WIDTH-1:0]         i_bus,
  input  logic                          i_cfgNWE,
  input  logic [chan_w(CHANNELS)-1:0]   i_cfgChannel,
  input  logic [1:0]                    i_cfgMode,
  input  logic [ADDR_WIDTH-1:0]         i_cfgAddr,
  input  logic [DATA_WIDTH-1:0]         i_cfgData,
  input  logic                          i_cfgDataMatch,
  input  logic [COUNT_WIDTH-1:0]        i_cfgPassCount,
  input  logic                          i_resume,
  output logic                          o_breakpointHitN,
  output logic [CHANNELS-1:0]           o_hitMask,
  output logic [chan_w(CHANNELS)-1:0]   o_hitChannel,
  output logic [1:0]                    o_dbgState
);

  localparam int CW = chan_w(CHANNELS);

  dbg_state_t          state, state_next;
  logic [CHANNELS-1:0] trig;
  logic [CW-1:0]       enc;
  logic                match_en, exec_en, reload;

  // HIT freezes all channels; SKIP swallows exec matches until the next fetch
  assign match_en = (state != HIT) && !i_breakpointEnableN;
  assign exec_en  = (state == ARMED);
  assign reload   = (state == HIT) && i_resume;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    breakpoint_channel #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_chan (
      .clk           (i_clk),
      .reset         (i_reset),
      .cfg_we        (!i_cfgNWE && (i_cfgChannel == CW'(c))),
      .cfg_mode      (i_cfgMode),
      .cfg_addr      (i_cfgAddr),
      .cfg_data      (i_cfgData),
      .cfg_data_match(i_cfgDataMatch),
      .cfg_pass_count(i_cfgPassCount),
      .match_en      (match_en),
      .exec_en       (exec_en),
      .reload        (reload),
      .instr_start   (i_instrStart),
      .pc            (i_pc),
      .ram_addr      (i_ramAddr),
      .ram_noe       (i_ramNOE),
      .ram_nwe       (i_ramNWE),
      .bus           (i_bus),
      .trigger       (trig[c])
    );
  end

  // Lowest-index triggered channel wins
  always_comb begin
    enc = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (trig[i]) enc = CW'(i);
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ARMED:   if (|trig) state_next = HIT;
      HIT:     if (i_resume) state_next = SKIP;
      SKIP: begin
        if (|trig)             state_next = HIT;
        else if (i_instrStart) state_next = ARMED;
      end
      default: state_next = ARMED;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ARMED;
    else         state <= state_next;
  end

  // Registered halt request and hit record, held until resume
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_breakpointHitN <= 1'b1;
      o_hitMask        <= '0;
      o_hitChannel     <= '0;
    end else begin
      o_breakpointHitN <= (state_next != HIT);
      if (state != HIT && |trig) begin
        o_hitMask    <= trig;
        o_hitChannel <= enc;
      end else if (reload) begin
        o_hitMask    <= '0;
        o_hitChannel <= '0;
      end
    end
  end

  assign o_dbgState = state;

endmodule
